// File: rtl/io_mux_pkg.sv
// ============================================================================
// Module   : io_mux_pkg
// Brief    : Shared state encoding and function-code helpers for io_mux_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_mux_pkg;

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    function automatic int fcount(input int rx, input int tx);
        return rx + tx;
    endfunction

    // One spare code above the last function so OFF is always representable.
    function automatic int fwidth(input int rx, input int tx);
        return $clog2(rx + tx + 1);
    endfunction

    function automatic int off_code(input int rx, input int tx);
        return rx + tx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_mux_pin_seq.sv
// ============================================================================
// Module   : io_mux_pin_seq
// Brief    : One pin's selection sequencer with turnaround, input synchroniser
//            and registered pad outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_mux_pin_seq
    import io_mux_pkg::*;
#(
    parameter int RXCOUNT     = 2,
    parameter int TXCOUNT     = 3,
    parameter int TURNAROUND  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FWIDTH      = fwidth(RXCOUNT, TXCOUNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hold,
    input  logic [FWIDTH-1:0]  i_func_select,
    input  logic [TXCOUNT-1:0] i_func_transmit,
    input  logic               i_pin_in,
    output logic               o_pin_ena,
    output logic               o_pin_out,
    output logic [RXCOUNT-1:0] o_func_receive,
    output logic               o_busy
);

    localparam int              CW         = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [CW-1:0]   c_CNT_LOAD = CW'(TURNAROUND - 1);
    localparam logic [FWIDTH-1:0] c_OFF    = FWIDTH'(off_code(RXCOUNT, TXCOUNT));

    logic [0:0]             r_state;
    logic [FWIDTH-1:0]      r_cur_sel;
    logic [FWIDTH-1:0]      r_pend;
    logic [CW-1:0]          r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pin_ena;
    logic                   r_pin_out;

    logic [0:0]             w_next_state;
    logic [FWIDTH-1:0]      w_next_sel;
    logic [FWIDTH-1:0]      w_next_pend;
    logic [CW-1:0]          w_next_cnt;
    logic                   w_tx_en;
    logic                   w_tx_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_RUN;
            r_cur_sel <= c_OFF;
            r_pend    <= c_OFF;
            r_cnt     <= '0;
            r_sync    <= '0;
            r_pin_ena <= 1'b0;
            r_pin_out <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cur_sel <= w_next_sel;
            r_pend    <= w_next_pend;
            r_cnt     <= w_next_cnt;
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_pin_in};
            r_pin_ena <= w_tx_en;
            r_pin_out <= w_tx_bit;
        end
    end

    // The pin is forced OFF on entry to DRAIN; a newer request restarts the wait.
    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_cur_sel;
        w_next_pend  = r_pend;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (!i_hold && (i_func_select != r_cur_sel)) begin
                    w_next_state = c_ST_DRAIN;
                    w_next_pend  = i_func_select;
                    w_next_cnt   = c_CNT_LOAD;
                    w_next_sel   = c_OFF;
                end
            end
            c_ST_DRAIN: begin
                if (!i_hold && (i_func_select != r_pend)) begin
                    w_next_pend = i_func_select;
                    w_next_cnt  = c_CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_next_sel   = r_pend;
                    w_next_state = c_ST_RUN;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_next_state = c_ST_RUN;
                w_next_sel   = c_OFF;
            end
        endcase
    end

    always_comb begin
        w_tx_en  = 1'b0;
        w_tx_bit = 1'b0;
        for (int t = 0; t < TXCOUNT; t++) begin
            if (w_next_sel == FWIDTH'(RXCOUNT + t)) begin
                w_tx_en  = 1'b1;
                w_tx_bit = i_func_transmit[t];
            end
        end
        o_func_receive = '0;
        for (int r = 0; r < RXCOUNT; r++) begin
            o_func_receive[r] = (r_cur_sel == FWIDTH'(r)) && r_sync[SYNC_STAGES-1];
        end
        o_busy = (r_state == c_ST_DRAIN);
    end

    assign o_pin_ena = r_pin_ena;
    assign o_pin_out = r_pin_out;

endmodule

`default_nettype wire

// File: rtl/io_mux_bank.sv
// ============================================================================
// Module   : io_mux_bank
// Brief    : Registered multi-pin IO function mux with glitch-free turnaround.
//            Optional selection lock enabled by defining IO_MUX_BANK_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_mux_bank
    import io_mux_pkg::*;
#(
    parameter int PINCOUNT    = 4,
    parameter int RXCOUNT     = 2,
    parameter int TXCOUNT     = 3,
    parameter int TURNAROUND  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
`ifdef IO_MUX_BANK_LOCK_EN
    input  logic                                           lock,
`endif
    output logic [PINCOUNT-1:0]                            pin_ena,
    output logic [PINCOUNT-1:0]                            pin_out,
    input  logic [PINCOUNT-1:0]                            pin_in,
    input  logic [PINCOUNT*fwidth(RXCOUNT, TXCOUNT)-1:0]   func_select,
    output logic [PINCOUNT*RXCOUNT-1:0]                    func_receive,
    input  logic [PINCOUNT*TXCOUNT-1:0]                    func_transmit,
    output logic [PINCOUNT-1:0]                            busy
);

    localparam int FWIDTH = fwidth(RXCOUNT, TXCOUNT);

    logic w_hold;

`ifdef IO_MUX_BANK_LOCK_EN
    // Sticky until reset; only blocks new requests, an active drain still lands.
    logic r_locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else if (lock) begin
            r_locked <= 1'b1;
        end
    end

    assign w_hold = r_locked;
`else
    assign w_hold = 1'b0;
`endif

    for (genvar p = 0; p < PINCOUNT; p++) begin : g_pin
        io_mux_pin_seq #(
            .RXCOUNT     (RXCOUNT),
            .TXCOUNT     (TXCOUNT),
            .TURNAROUND  (TURNAROUND),
            .SYNC_STAGES (SYNC_STAGES),
            .FWIDTH      (FWIDTH)
        ) u_seq (
            .clk             (clk),
            .rst             (rst),
            .i_hold          (w_hold),
            .i_func_select   (func_select[p*FWIDTH +: FWIDTH]),
            .i_func_transmit (func_transmit[p*TXCOUNT +: TXCOUNT]),
            .i_pin_in        (pin_in[p]),
            .o_pin_ena       (pin_ena[p]),
            .o_pin_out       (pin_out[p]),
            .o_func_receive  (func_receive[p*RXCOUNT +: RXCOUNT]),
            .o_busy          (busy[p])
        );
    end

endmodule

`default_nettype wire
